// File: rtl/mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} mem_state_t;

  typedef enum logic [1:0] {DEC_RAM, DEC_IO, DEC_UNMAPPED} mem_dec_t;

  // Request fields captured at acceptance
  typedef struct packed {
    logic              we;
    logic [15:0]       addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Address decode; the I/O word wins over the RAM range
  function automatic mem_dec_t mem_decode(input logic [15:0] addr,
                                          input logic [15:0] io_addr,
                                          input int unsigned addr_w);
    if (addr == io_addr) return DEC_IO;
    if ((32'(addr) >> addr_w) == 32'd0) return DEC_RAM;
    return DEC_UNMAPPED;
  endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port synchronous RAM; read data registered one cycle after the address.
module mem_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  // Write-enable store and registered read (contents are never reset)
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: wait-stated RAM access plus one memory-mapped I/O word.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              WE,
  input  logic [15:0]       ADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W-1:0] Switches,
  output logic [DATA_W-1:0] RDATA,
  output logic              R,
  output logic              ERR,
  output logic              Busy,
  output logic [DATA_W-1:0] HEX_Out
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);
  localparam bit               HAS_WAIT  = (WAIT_STATES != 32'd0);

  mem_state_t        r_state;
  mem_state_t        w_next_state;
  mem_req_t          r_req;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_io_data;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_hex;
  logic              r_r;
  logic              r_err;
  logic              r_busy;

  mem_dec_t          w_dec;
  logic              w_accept;
  logic              w_ram_we;
  logic              w_hex_we;
  logic              w_sample_io;
  logic              w_complete;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [DATA_W-1:0] w_read_data;

  assign w_dec = mem_decode(r_req.addr, IO_ADDR, ADDR_W);

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; WAIT is skipped entirely when there are no wait states
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (Req) w_next_state = HAS_WAIT ? WAIT : ACCESS;
      WAIT:    if (r_cnt == CNT_W'(1)) w_next_state = ACCESS;
      ACCESS:  w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    w_accept    = 1'b0;
    w_ram_we    = 1'b0;
    w_hex_we    = 1'b0;
    w_sample_io = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE:   w_accept = Req;
      ACCESS: begin
        w_sample_io = 1'b1;
        w_ram_we    = r_req.we && (w_dec == DEC_RAM);
        w_hex_we    = r_req.we && (w_dec == DEC_IO);
      end
      DONE:   w_complete = 1'b1;
      default: ;
    endcase
  end

  // Read result selection for the completing request
  always_comb begin
    w_read_data = '0;
    case (w_dec)
      DEC_RAM: w_read_data = w_ram_rdata;
      DEC_IO:  w_read_data = r_io_data;
      default: ;
    endcase
  end

  // Request latch and wait-state counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_req <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_req <= '{we: WE, addr: ADDR, wdata: WDATA};
      r_cnt <= WAIT_INIT;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Switch sample taken in ACCESS, alongside the RAM read
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)            r_io_data <= '0;
    else if (w_sample_io) r_io_data <= Switches;
  end

  // Response outputs; Busy covers acceptance through the R cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_r     <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_r    <= w_complete;
      r_err  <= w_complete && (w_dec == DEC_UNMAPPED);
      r_busy <= (r_state != IDLE) || w_accept;
      if (w_complete && !r_req.we) r_rdata <= w_read_data;
    end
  end

  // Hex display register, loaded by stores to the I/O word
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)         r_hex <= '0;
    else if (w_hex_we) r_hex <= r_req.wdata;
  end

  mem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (Clk),
    .i_we    (w_ram_we),
    .i_addr  (r_req.addr[ADDR_W-1:0]),
    .i_wdata (r_req.wdata),
    .o_rdata (w_ram_rdata)
  );

  assign RDATA   = r_rdata;
  assign R       = r_r;
  assign ERR     = r_err;
  assign Busy    = r_busy;
  assign HEX_Out = r_hex;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) share one stimulus
// stream and are checked every cycle against a transaction-timeline model.
module tb_mem_responder;

  localparam int WS0 = 2;
  localparam int WS1 = 0;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        WE = 1'b0;
  logic [15:0] ADDR = 16'h0;
  logic [15:0] WDATA = 16'h0;
  logic [15:0] Switches = 16'h0;

  logic [15:0] rdata0, rdata1, hex0, hex1;
  logic        r0, r1, err0, err1, busy0, busy1;

  always #5 Clk = ~Clk;

  mem_responder #(.ADDR_W(8), .WAIT_STATES(WS0), .IO_ADDR(16'hFFFF)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .Switches(Switches), .RDATA(rdata0), .R(r0), .ERR(err0), .Busy(busy0), .HEX_Out(hex0));

  mem_responder #(.ADDR_W(8), .WAIT_STATES(WS1), .IO_ADDR(16'hFFFF)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .Switches(Switches), .RDATA(rdata1), .R(r1), .ERR(err1), .Busy(busy1), .HEX_Out(hex1));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: one outstanding request per DUT, timed by edge number
  bit          m_pend[2];
  int          m_acc[2];
  bit          m_we[2];
  logic [15:0] m_addr[2];
  logic [15:0] m_wdata[2];
  logic [15:0] m_res[2];
  bit          m_res_known[2];
  bit          m_res_err[2];
  logic [15:0] m_mem[2][256];
  bit          m_known[2][256];

  bit          e_r[2];
  bit          e_err[2];
  bit          e_busy[2];
  bit          e_rd_known[2];
  logic [15:0] e_rdata[2];
  logic [15:0] e_hex[2];

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, i, act, exp, cyc);
    end
  endtask

  function automatic int ws_of(input int i);
    return (i == 0) ? WS0 : WS1;
  endfunction

  // 0 = RAM, 1 = I/O word, 2 = unmapped
  function automatic int region(input logic [15:0] a);
    if (a == 16'hFFFF) return 1;
    if (a < 16'd256)   return 0;
    return 2;
  endfunction

  // Accept at edge k, operate at edge k+WS+1, respond after edge k+WS+2
  task automatic model_step(input int i);
    int w;
    bit was_idle;
    w = ws_of(i);
    if (Reset) begin
      m_pend[i] = 0; e_r[i] = 0; e_err[i] = 0; e_busy[i] = 0;
      e_rdata[i] = 16'h0; e_rd_known[i] = 1; e_hex[i] = 16'h0;
    end else begin
      was_idle = !m_pend[i];
      e_r[i] = 0;
      e_err[i] = 0;
      if (m_pend[i] && cyc == m_acc[i] + w + 1) begin
        m_res_err[i] = 0;
        case (region(m_addr[i]))
          0: if (m_we[i]) begin
               m_mem[i][m_addr[i][7:0]] = m_wdata[i];
               m_known[i][m_addr[i][7:0]] = 1;
             end else begin
               m_res[i] = m_mem[i][m_addr[i][7:0]];
               m_res_known[i] = m_known[i][m_addr[i][7:0]];
             end
          1: if (m_we[i]) e_hex[i] = m_wdata[i];
             else begin m_res[i] = Switches; m_res_known[i] = 1; end
          default: begin m_res[i] = 16'h0; m_res_known[i] = 1; m_res_err[i] = 1; end
        endcase
      end
      if (m_pend[i] && cyc == m_acc[i] + w + 2) begin
        e_r[i] = 1;
        e_err[i] = m_res_err[i];
        if (!m_we[i]) begin e_rdata[i] = m_res[i]; e_rd_known[i] = m_res_known[i]; end
        m_pend[i] = 0;
      end
      if (was_idle && Req) begin
        m_pend[i] = 1; m_acc[i] = cyc; m_we[i] = WE; m_addr[i] = ADDR; m_wdata[i] = WDATA;
      end
      e_busy[i] = m_pend[i] || e_r[i];
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      e_rdata[i] = 16'h0; e_hex[i] = 16'h0; e_rd_known[i] = 1;
      for (int a = 0; a < 256; a++) m_known[i][a] = 0;
    end
    forever begin
      @(posedge Clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  task automatic compare_one(input int i);
    logic [15:0] a_rd, a_hex;
    logic a_r, a_err, a_busy;
    a_rd   = (i == 0) ? rdata0 : rdata1;
    a_hex  = (i == 0) ? hex0   : hex1;
    a_r    = (i == 0) ? r0     : r1;
    a_err  = (i == 0) ? err0   : err1;
    a_busy = (i == 0) ? busy0  : busy1;
    if (Reset) begin
      chk("rst_R", i, 32'(a_r), 32'd0);
      chk("rst_Busy", i, 32'(a_busy), 32'd0);
      chk("rst_RDATA", i, 32'(a_rd), 32'd0);
      chk("rst_HEX", i, 32'(a_hex), 32'd0);
    end else begin
      chk("R", i, 32'(a_r), 32'(e_r[i]));
      chk("ERR", i, 32'(a_err), 32'(e_err[i]));
      chk("Busy", i, 32'(a_busy), 32'(e_busy[i]));
      chk("HEX_Out", i, 32'(a_hex), 32'(e_hex[i]));
      if (e_rd_known[i]) chk("RDATA", i, 32'(a_rd), 32'(e_rdata[i]));
    end
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++) compare_one(i);
    end
  end

  // One request; lat = edges from acceptance to the R edge on dut0
  task automatic do_req(input bit we, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output bit e);
    @(posedge Clk); #2;
    Req = 1'b1; WE = we; ADDR = a; WDATA = d;
    @(posedge Clk); #2;
    Req = 1'b0;
    lat = -1; rd = 16'h0; e = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (r0) begin lat = n - 1; rd = rdata0; e = err0; break; end
    end
    if (lat < 0) begin
      n_checks++; n_errors++;
      $display("FAIL req_timeout dut0: got no R expected R within 20 cycles (addr %0h)", a);
    end
  endtask

  int          lat;
  logic [15:0] rd;
  bit          e;
  int          rcount;
  logic [15:0] got;
  int          last;

  initial begin
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b0;
    @(negedge Clk);
    chk("init_R", 0, 32'(r0), 32'd0);
    chk("init_Busy", 0, 32'(busy0), 32'd0);
    chk("init_RDATA", 0, 32'(rdata0), 32'd0);
    chk("init_HEX", 0, 32'(hex0), 32'd0);

    // Write then read back
    do_req(1'b1, 16'h0010, 16'h1234, lat, rd, e);
    chk("t1_wr_lat", 0, 32'(lat), 32'd4);
    chk("t1_wr_err", 0, 32'(e), 32'd0);
    do_req(1'b0, 16'h0010, 16'h0000, lat, rd, e);
    chk("t1_rd_lat", 0, 32'(lat), 32'd4);
    chk("t1_rd_data", 0, 32'(rd), 32'h1234);
    chk("t1_rd_err", 0, 32'(e), 32'd0);

    // I/O word: switches in, hex out, RAM alias untouched
    Switches = 16'hA5A5;
    do_req(1'b1, 16'h00FF, 16'h5555, lat, rd, e);
    do_req(1'b0, 16'hFFFF, 16'h0000, lat, rd, e);
    chk("t2_sw_data", 0, 32'(rd), 32'hA5A5);
    do_req(1'b1, 16'hFFFF, 16'h00BE, lat, rd, e);
    chk("t2_hex", 0, 32'(hex0), 32'h00BE);
    do_req(1'b0, 16'h00FF, 16'h0000, lat, rd, e);
    chk("t2_ram_kept", 0, 32'(rd), 32'h5555);

    // Unmapped address
    do_req(1'b1, 16'h0000, 16'h1111, lat, rd, e);
    do_req(1'b0, 16'h0400, 16'h0000, lat, rd, e);
    chk("t3_rd_data", 0, 32'(rd), 32'h0000);
    chk("t3_rd_err", 0, 32'(e), 32'd1);
    do_req(1'b1, 16'h0400, 16'hBAD0, lat, rd, e);
    chk("t3_wr_err", 0, 32'(e), 32'd1);
    do_req(1'b0, 16'h0000, 16'h0000, lat, rd, e);
    chk("t3_ram_kept", 0, 32'(rd), 32'h1111);
    chk("t3_ok_err", 0, 32'(e), 32'd0);

    // Input stability: extra Req pulses in WAIT and DONE, ADDR changed after acceptance
    @(posedge Clk); #2;
    Req = 1'b1; WE = 1'b0; ADDR = 16'h0010;
    @(posedge Clk); #2;
    Req = 1'b0; ADDR = 16'h00FF;
    rcount = 0; got = 16'h0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge Clk);
      if (n <= 5) chk("t4_busy", 0, 32'(busy0), 32'd1);
      if (r0) begin rcount++; got = rdata0; end
      case (n)
        1: Req = 1'b1;
        2: Req = 1'b0;
        4: Req = 1'b1;
        5: Req = 1'b0;
        default: ;
      endcase
    end
    chk("t4_one_R", 0, 32'(rcount), 32'd1);
    chk("t4_data", 0, 32'(got), 32'h1234);
    repeat (4) @(posedge Clk);

    // Reset during WAIT aborts the write
    do_req(1'b1, 16'h0020, 16'h7777, lat, rd, e);
    @(posedge Clk); #2;
    Req = 1'b1; WE = 1'b1; ADDR = 16'h0020; WDATA = 16'h9999;
    @(posedge Clk); #2;
    Req = 1'b0;
    @(posedge Clk); #2;
    Reset = 1'b1;
    #1;
    chk("t5_imm_R", 0, 32'(r0), 32'd0);
    chk("t5_imm_Busy", 0, 32'(busy0), 32'd0);
    chk("t5_imm_RDATA", 0, 32'(rdata0), 32'd0);
    chk("t5_imm_HEX", 0, 32'(hex0), 32'd0);
    @(posedge Clk);
    @(posedge Clk); #2;
    Reset = 1'b0;
    rcount = 0;
    repeat (8) begin
      @(negedge Clk);
      if (r0) rcount++;
    end
    chk("t5_no_R", 0, 32'(rcount), 32'd0);
    do_req(1'b0, 16'h0020, 16'h0000, lat, rd, e);
    chk("t5_old_data", 0, 32'(rd), 32'h7777);

    // Zero wait states with Req held high: one response every 3 cycles
    @(posedge Clk); #2;
    Req = 1'b1; WE = 1'b1; ADDR = 16'h0003; WDATA = 16'hC0DE;
    rcount = 0; last = -1;
    for (int n = 0; n < 15; n++) begin
      @(negedge Clk);
      if (r1) begin
        if (last >= 0) chk("t6_period", 1, 32'(n - last), 32'd3);
        last = n;
        rcount++;
      end
      WE = 1'($urandom);
      ADDR = {13'd0, 3'($urandom)};
      WDATA = 16'($urandom);
    end
    Req = 1'b0;
    chk("t6_count", 1, 32'(rcount), 32'd4);
    repeat (6) @(posedge Clk);

    // Randomized traffic, including occasional resets
    for (int n = 0; n < 400; n++) begin
      @(posedge Clk); #2;
      Reset = ($urandom_range(0, 99) == 0);
      Req = ($urandom_range(0, 2) != 0);
      WE = 1'($urandom);
      WDATA = 16'($urandom);
      Switches = 16'($urandom);
      case ($urandom_range(0, 5))
        3:       ADDR = 16'hFFFF;
        4:       ADDR = 16'h0100 + 16'($urandom_range(0, 1023));
        5:       ADDR = 16'hFFFE;
        default: ADDR = {12'd0, 4'($urandom)};
      endcase
    end
    @(posedge Clk); #2;
    Reset = 1'b0; Req = 1'b0;
    repeat (10) @(posedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
